// File: rtl/vx_gbar_unit.sv
// vx_gbar_unit -- cluster-level global barrier responder.
// Collects per-core arrivals for each barrier id from the merged gbar request
// stream. When the expected core count is reached, it broadcasts a one-cycle
// release for that id.
// Optional feature macro: VX_GBAR_PERF_EN adds perf_releases / perf_wait_cyc.
module vx_gbar_unit #(
   parameter int NUM_BARRIERS = 16,
   parameter int NUM_CORES    = 4,
   localparam int IDW = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
   localparam int CW  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           req_valid,
   input  logic [IDW-1:0] req_id,
   input  logic [CW-1:0]  req_size_m1,
   input  logic [CW-1:0]  req_core_id,
   output logic           req_ready,
   output logic           rsp_valid,
   output logic [IDW-1:0] rsp_id,
   output logic           err_dup,
   output logic           err_size
`ifdef VX_GBAR_PERF_EN
   ,
   output logic [31:0]    perf_releases,
   output logic [31:0]    perf_wait_cyc
`endif
);

   // Number of set bits in an arrival mask, one bit wider than a core index.
   function automatic logic [CW:0] popcnt(input logic [NUM_CORES-1:0] v);
      logic [CW:0] c;
      c = {(CW+1){1'b0}};
      for (int i = 0; i < NUM_CORES; i++) begin
         c = c + {{CW{1'b0}}, v[i]};
      end
      return c;
   endfunction

   logic [NUM_CORES-1:0] mask_q [NUM_BARRIERS];
   logic [NUM_CORES-1:0] mask_d [NUM_BARRIERS];
   logic [CW-1:0]        size_q [NUM_BARRIERS];
   logic [CW-1:0]        size_d [NUM_BARRIERS];
   logic [NUM_BARRIERS-1:0] size_valid_q, size_valid_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]       rsp_id_q, rsp_id_d;
   logic                 err_dup_q, err_dup_d;
   logic                 err_size_q, err_size_d;

   logic                 accept_s;
   logic                 core_oob_s;
   logic [NUM_CORES-1:0] core_bit_s;
   logic [NUM_CORES-1:0] cur_mask_s;
   logic [NUM_CORES-1:0] new_mask_s;
   logic                 first_s;
   logic                 dup_s;
   logic [CW-1:0]        eff_size_s;
   logic                 release_s;
   logic                 any_pend_s;

   // Ready is simply "not in reset": the unit can absorb one request every cycle.
   assign req_ready = ~reset;
   assign accept_s  = req_valid & ~reset;

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign err_dup   = err_dup_q;
   assign err_size  = err_size_q;

   // Decode the incoming arrival against the addressed barrier's state.
   always_comb begin
      core_oob_s = ({1'b0, req_core_id} >= (CW+1)'(NUM_CORES));
      core_bit_s = core_oob_s ? {NUM_CORES{1'b0}} : (NUM_CORES'(1'b1) << req_core_id);
      cur_mask_s = mask_q[req_id];
      new_mask_s = cur_mask_s | core_bit_s;
      first_s    = (cur_mask_s == {NUM_CORES{1'b0}});
      dup_s      = core_oob_s | (|(cur_mask_s & core_bit_s));
      eff_size_s = size_valid_q[req_id] ? size_q[req_id] : req_size_m1;
      // eff_size+1 is formed at CW+1 bits so a full-width size cannot wrap.
      release_s  = (popcnt(new_mask_s) == ({1'b0, eff_size_s} + {{CW{1'b0}}, 1'b1}));
   end

   // Any barrier with at least one pending arrival.
   always_comb begin
      any_pend_s = 1'b0;
      for (int b = 0; b < NUM_BARRIERS; b++) begin
         any_pend_s = any_pend_s | (|mask_q[b]);
      end
   end

   // Next-state for the barrier table, release pulse and sticky errors.
   always_comb begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
         mask_d[b] = mask_q[b];
         size_d[b] = size_q[b];
      end
      size_valid_d = size_valid_q;
      rsp_valid_d  = 1'b0;
      rsp_id_d     = rsp_id_q;
      err_dup_d    = err_dup_q;
      err_size_d   = err_size_q;
      if (accept_s) begin
         if (dup_s) begin
            // Repeat or out-of-range core: flag it, leave the barrier untouched.
            err_dup_d = 1'b1;
         end else begin
            if (!first_s && (req_size_m1 != size_q[req_id])) begin
               err_size_d = 1'b1;
            end else begin
               err_size_d = err_size_q;
            end
            if (release_s) begin
               mask_d[req_id]       = {NUM_CORES{1'b0}};
               size_valid_d[req_id] = 1'b0;
               rsp_valid_d          = 1'b1;
               rsp_id_d             = req_id;
            end else begin
               mask_d[req_id] = new_mask_s;
               if (first_s) begin
                  size_d[req_id]       = req_size_m1;
                  size_valid_d[req_id] = 1'b1;
               end else begin
                  size_d[req_id]       = size_q[req_id];
               end
            end
         end
      end else begin
         rsp_valid_d = 1'b0;
      end
   end

   // State registers with synchronous reset; reset discards all pending barriers.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int b = 0; b < NUM_BARRIERS; b++) begin
            mask_q[b] <= {NUM_CORES{1'b0}};
            size_q[b] <= {CW{1'b0}};
         end
         size_valid_q <= {NUM_BARRIERS{1'b0}};
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= {IDW{1'b0}};
         err_dup_q    <= 1'b0;
         err_size_q   <= 1'b0;
      end else begin
         for (int b = 0; b < NUM_BARRIERS; b++) begin
            mask_q[b] <= mask_d[b];
            size_q[b] <= size_d[b];
         end
         size_valid_q <= size_valid_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         err_dup_q    <= err_dup_d;
         err_size_q   <= err_size_d;
      end
   end

`ifdef VX_GBAR_PERF_EN
   logic [31:0] perf_releases_q, perf_releases_d;
   logic [31:0] perf_wait_cyc_q, perf_wait_cyc_d;

   // Release count wraps; wait-cycle count saturates at all-ones.
   always_comb begin
      perf_releases_d = perf_releases_q + (rsp_valid_d ? 32'd1 : 32'd0);
      if (any_pend_s && (perf_wait_cyc_q != 32'hFFFF_FFFF)) begin
         perf_wait_cyc_d = perf_wait_cyc_q + 32'd1;
      end else begin
         perf_wait_cyc_d = perf_wait_cyc_q;
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_releases_q <= 32'd0;
         perf_wait_cyc_q <= 32'd0;
      end else begin
         perf_releases_q <= perf_releases_d;
         perf_wait_cyc_q <= perf_wait_cyc_d;
      end
   end

   assign perf_releases = perf_releases_q;
   assign perf_wait_cyc = perf_wait_cyc_q;
`else
   logic unused_pend_s;
   assign unused_pend_s = any_pend_s;
`endif

endmodule
